// File: rtl/conv3x3_pkg.sv
// Shared types and helpers for the 3x3 streaming convolution engine.
package conv3x3_pkg;

   typedef enum logic [1:0] {
      MODE_PASS  = 2'd0,
      MODE_SOBEL = 2'd1,
      MODE_GAUSS = 2'd2,
      MODE_SHARP = 2'd3
   } mode_e;

   // Headroom above PIX_W that holds the largest kernel sum and its sign.
   localparam int ACC_GUARD_W = 5;

   function automatic int clamp_pix(input int v, input int hi);
      if (v < 0)  return 0;
      if (v > hi) return hi;
      return v;
   endfunction

endpackage

// File: rtl/conv3x3_kernel.sv
// Combinational 3x3 kernel: window in, clamped pixel out.
// win_i[row][col], row 0 is the oldest line, col 0 the oldest column.
module conv3x3_kernel
   import conv3x3_pkg::*;
#(
   parameter int PIX_W = 4,
   parameter int SHIFT = 2
) (
   input  logic [2:0][2:0][PIX_W-1:0] win_i,
   input  mode_e                      mode_i,
   output logic [PIX_W-1:0]           pix_o
);

   localparam int ACC_W   = PIX_W + ACC_GUARD_W;
   localparam int PIX_MAX = (1 << PIX_W) - 1;

   typedef logic signed [ACC_W-1:0] acc_t;

   acc_t p [3][3];
   acc_t gx, gy, ax, ay, acc;

   always_comb begin
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            p[i][j] = acc_t'(win_i[i][j]);

      gx = (p[0][2] + (p[1][2] <<< 1) + p[2][2]) - (p[0][0] + (p[1][0] <<< 1) + p[2][0]);
      gy = (p[2][0] + (p[2][1] <<< 1) + p[2][2]) - (p[0][0] + (p[0][1] <<< 1) + p[0][2]);
      ax = gx[ACC_W-1] ? -gx : gx;
      ay = gy[ACC_W-1] ? -gy : gy;

      case (mode_i)
         MODE_SOBEL: acc = (ax + ay) >>> SHIFT;
         MODE_GAUSS: acc = (p[0][0] + p[0][2] + p[2][0] + p[2][2]
                           + ((p[0][1] + p[1][0] + p[1][2] + p[2][1]) <<< 1)
                           + (p[1][1] <<< 2)) >>> 4;
         MODE_SHARP: acc = (p[1][1] <<< 2) + p[1][1] - p[0][1] - p[2][1] - p[1][0] - p[1][2];
         default:    acc = p[1][1];
      endcase

      pix_o = PIX_W'(clamp_pix(int'(acc), PIX_MAX));
   end

endmodule

// File: rtl/conv3x3_stream.sv
// Raster-order 3x3 convolution: line buffers, position counters, two-stage
// pipeline (window load, then kernel) with border masking and sync checks.
module conv3x3_stream
   import conv3x3_pkg::*;
#(
   parameter int PIX_W       = 4,
   parameter int IMG_W       = 640,
   parameter int IMG_H       = 480,
   parameter int SOBEL_SHIFT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_sof,
   input  logic [PIX_W-1:0] pixel_in,
   input  logic [1:0]       mode,
   output logic             out_valid,
   output logic [PIX_W-1:0] pixel_out,
   output logic             out_border,
   output logic             frame_done,
   output logic             sync_err
);

   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
   localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
   localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

   logic [PIX_W-1:0] line0_q [IMG_W];
   logic [PIX_W-1:0] line1_q [IMG_W];

   logic [COL_W-1:0] col_q, col_d, beat_col;
   logic [ROW_W-1:0] row_q, row_d, beat_row;
   mode_e            mode_q, beat_mode;

   logic [2:0][2:0][PIX_W-1:0] win_q, win_d;

   logic       v1_q, border1_q, last1_q, serr1_q;
   mode_e      mode1_q;

   logic [PIX_W-1:0] kern_pix;
   logic             out_valid_q, out_border_q, frame_done_q, sync_err_q;
   logic [PIX_W-1:0] pixel_out_q;

   // A sof beat is position (0,0) and carries its own mode, whatever the counters say.
   always_comb begin
      beat_row  = in_sof ? '0 : row_q;
      beat_col  = in_sof ? '0 : col_q;
      beat_mode = in_sof ? mode_e'(mode) : mode_q;

      col_d = col_q;
      row_d = row_q;
      win_d = win_q;
      if (in_valid) begin
         if (beat_col == COL_LAST) begin
            col_d = '0;
            row_d = (beat_row == ROW_LAST) ? '0 : beat_row + ROW_W'(1);
         end else begin
            col_d = beat_col + COL_W'(1);
            row_d = beat_row;
         end
         for (int i = 0; i < 3; i++) begin
            win_d[i][0] = win_q[i][1];
            win_d[i][1] = win_q[i][2];
         end
         win_d[0][2] = line0_q[beat_col];
         win_d[1][2] = line1_q[beat_col];
         win_d[2][2] = pixel_in;
      end
   end

   // NOTE: line buffers have no reset; every read of stale data lands in a
   // border-masked window, so clearing them would only cost a reset fan-out.
   always_ff @(posedge clk) begin
      if (in_valid) begin
         line0_q[beat_col] <= line1_q[beat_col];
         line1_q[beat_col] <= pixel_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row_q        <= '0;
         col_q        <= '0;
         win_q        <= '0;
         mode_q       <= MODE_PASS;
         v1_q         <= 1'b0;
         border1_q    <= 1'b0;
         last1_q      <= 1'b0;
         serr1_q      <= 1'b0;
         mode1_q      <= MODE_PASS;
         out_valid_q  <= 1'b0;
         pixel_out_q  <= '0;
         out_border_q <= 1'b0;
         frame_done_q <= 1'b0;
         sync_err_q   <= 1'b0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
         win_q <= win_d;
         if (in_valid && in_sof)
            mode_q <= mode_e'(mode);

         v1_q <= in_valid;
         if (in_valid) begin
            border1_q <= (beat_row < ROW_TWO) || (beat_col < COL_TWO);
            last1_q   <= (beat_row == ROW_LAST) && (beat_col == COL_LAST);
            serr1_q   <= in_sof && ((row_q != '0) || (col_q != '0));
            mode1_q   <= beat_mode;
         end

         out_valid_q  <= v1_q;
         out_border_q <= v1_q & border1_q;
         frame_done_q <= v1_q & last1_q;
         sync_err_q   <= v1_q & serr1_q;
         if (v1_q)
            pixel_out_q <= border1_q ? '0 : kern_pix;
      end
   end

   conv3x3_kernel #(
      .PIX_W (PIX_W),
      .SHIFT (SOBEL_SHIFT)
   ) u_kernel (
      .win_i  (win_q),
      .mode_i (mode1_q),
      .pix_o  (kern_pix)
   );

   assign out_valid  = out_valid_q;
   assign pixel_out  = pixel_out_q;
   assign out_border = out_border_q;
   assign frame_done = frame_done_q;
   assign sync_err   = sync_err_q;

endmodule
